// File: rtl/goc_pkg.sv
// goc_pkg: shared types and defaults for the golden-circuit sequencer.
// State encoding and counter width used by goc_sequencer and its counters.
package goc_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/goc_sat_counter.sv
// goc_sat_counter: up-counter with synchronous clear that sticks at all-ones.
// Used for the latency counter and the statistics counters.
module goc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/goc_sequencer.sv
// goc_sequencer: drives one test vector into a DUT, waits for its result
// or a timeout, and hands the captured result on with latency and stats.
module goc_sequencer
  import goc_pkg::*;
#(
  parameter int TV_W  = 111,
  parameter int RV_W  = 200,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic [CNT_W-1:0] timeout_limit,
  input  logic             tv_valid,
  output logic             tv_ready,
  input  logic [TV_W-1:0]  tv_data,
  output logic [TV_W-1:0]  dut_in,
  output logic             dut_start,
  input  logic             dut_ready,
  input  logic             dut_valid,
  output logic             dut_request,
  input  logic [RV_W-1:0]  dut_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RV_W-1:0]  res_data,
  output logic             res_timeout,
  output logic [CNT_W-1:0] res_cycles,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] to_count,
  output logic             busy
);

  state_t           r_state;
  state_t           w_next;
  logic             r_tv_ready;
  logic             r_start;
  logic             r_req;
  logic [TV_W-1:0]  r_dut_in;
  logic [RV_W-1:0]  r_res_data;
  logic             r_res_to;
  logic [CNT_W-1:0] r_res_cyc;
  logic [CNT_W-1:0] w_lat;
  logic             w_active;
  logic             w_accept;
  logic             w_to_hit;
  logic             w_cap;
  logic             w_tout;
  logic             w_launch;

  assign w_active = (r_state == S_LAUNCH) || (r_state == S_WAIT);
  assign w_accept = (r_state == S_IDLE) && r_tv_ready && tv_valid && !abort;
  assign w_to_hit = (timeout_limit != '0) && (w_lat == timeout_limit);
  assign w_cap    = (r_state == S_WAIT) && dut_valid && !abort;
  // a result arriving on the timeout cycle wins over the timeout
  assign w_tout   = w_active && w_to_hit && !w_cap && !abort;
  assign w_launch = (r_state == S_LAUNCH) && dut_ready && !w_to_hit && !abort;

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   if (w_accept) w_next = S_LAUNCH;
        S_LAUNCH: begin
          if (w_tout)         w_next = S_DONE;
          else if (w_launch)  w_next = S_WAIT;
        end
        S_WAIT:   if (w_cap || w_tout) w_next = S_DONE;
        S_DONE:   if (res_ready) w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tv_ready <= 1'b0;
      r_start    <= 1'b0;
      r_req      <= 1'b0;
      r_dut_in   <= '0;
      r_res_data <= '0;
      r_res_to   <= 1'b0;
      r_res_cyc  <= '0;
    end else begin
      r_state    <= w_next;
      r_tv_ready <= (w_next == S_IDLE);
      r_start    <= w_launch;
      r_req      <= w_cap;
      if (w_accept) r_dut_in <= tv_data;
      if (w_cap) begin
        r_res_data <= dut_result;
        r_res_to   <= 1'b0;
        r_res_cyc  <= w_lat;
      end else if (w_tout) begin
        r_res_data <= '0;
        r_res_to   <= 1'b1;
        r_res_cyc  <= timeout_limit;
      end
    end
  end

  goc_sat_counter #(.W(CNT_W)) u_lat (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (w_accept),
    .i_inc (w_active),
    .o_q   (w_lat)
  );

  goc_sat_counter #(.W(CNT_W)) u_vec (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (1'b0),
    .i_inc (w_cap || w_tout),
    .o_q   (vec_count)
  );

  goc_sat_counter #(.W(CNT_W)) u_to (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (1'b0),
    .i_inc (w_tout),
    .o_q   (to_count)
  );

  assign tv_ready    = r_tv_ready;
  assign dut_in      = r_dut_in;
  assign dut_start   = r_start;
  assign dut_request = r_req;
  assign res_valid   = (r_state == S_DONE);
  assign res_data    = r_res_data;
  assign res_timeout = r_res_to;
  assign res_cycles  = r_res_cyc;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_goc_sequencer.sv
// tb_goc_sequencer: random and directed transactions against a
// transaction-level model of accept/launch/result/timeout timing.
module tb_goc_sequencer;

  localparam int TV_W  = 111;
  localparam int RV_W  = 200;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             abort;
  logic [CNT_W-1:0] timeout_limit;
  logic             tv_valid;
  logic             tv_ready;
  logic [TV_W-1:0]  tv_data;
  logic [TV_W-1:0]  dut_in;
  logic             dut_start;
  logic             dut_ready;
  logic             dut_valid;
  logic             dut_request;
  logic [RV_W-1:0]  dut_result;
  logic             res_valid;
  logic             res_ready;
  logic [RV_W-1:0]  res_data;
  logic             res_timeout;
  logic [CNT_W-1:0] res_cycles;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] to_count;
  logic             busy;

  int n_chk = 0;
  int n_err = 0;
  int m_vec = 0;
  int m_to  = 0;

  goc_sequencer #(.TV_W(TV_W), .RV_W(RV_W), .CNT_W(CNT_W)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .abort         (abort),
    .timeout_limit (timeout_limit),
    .tv_valid      (tv_valid),
    .tv_ready      (tv_ready),
    .tv_data       (tv_data),
    .dut_in        (dut_in),
    .dut_start     (dut_start),
    .dut_ready     (dut_ready),
    .dut_valid     (dut_valid),
    .dut_request   (dut_request),
    .dut_result    (dut_result),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_timeout   (res_timeout),
    .res_cycles    (res_cycles),
    .vec_count     (vec_count),
    .to_count      (to_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RV_W-1:0] rand_rv();
    logic [RV_W-1:0] x = '0;
    repeat (7) x = {x[RV_W-33:0], 32'($urandom)};
    return x;
  endfunction

  function automatic logic [TV_W-1:0] rand_tv();
    logic [TV_W-1:0] x = '0;
    repeat (4) x = {x[TV_W-33:0], 32'($urandom)};
    return x;
  endfunction

  function automatic int sat_inc(input int c);
    return (c == (1 << CNT_W) - 1) ? c : c + 1;
  endfunction

  task automatic offer(input logic [TV_W-1:0] tv, input int lim);
    int k = 0;
    while (!tv_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("tv_ready_pre", tv_ready, 1);
    tv_valid      = 1'b1;
    tv_data       = tv;
    timeout_limit = lim[CNT_W-1:0];
    dut_valid     = 1'b0;
    dut_ready     = 1'b0;
    @(posedge clk);
    #1 tv_valid = 1'b0;
  endtask

  // d: LAUNCH cycles with dut_ready low; v: cycle index (accept=0) of dut_valid
  task automatic run_vec(input logic [TV_W-1:0] tv, input logic [RV_W-1:0] rv,
                         input int d, input int v, input int lim,
                         input bit spur, input int hold);
    int starts = 0;
    int start_at = -1;
    int reqs = 0;
    int lat = -1;
    bit tout;
    int cyc;
    bit stable = 1'b1;
    logic [RV_W-1:0] snap;
    offer(tv, lim);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (dut_start) begin
        starts++;
        start_at = k;
      end
      if (dut_request) reqs++;
      if (res_valid) begin
        lat = k;
        break;
      end
      dut_ready  = (k >= d);
      dut_valid  = (k == v) || (spur && k == 0 && d > 0);
      dut_result = (k == v) ? rv : rand_rv();
    end
    dut_valid = 1'b0;
    snap = res_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (dut_start) starts++;
      if (dut_request) reqs++;
      if (!res_valid || tv_ready || res_data !== snap) stable = 1'b0;
    end
    tout = (lim != 0) && (lim < v);
    cyc  = tout ? lim : v;
    if (tout) m_to = sat_inc(m_to);
    m_vec = sat_inc(m_vec);
    chk("latency", lat, cyc + 1);
    chk("res_timeout", res_timeout, tout);
    chk("res_cycles", res_cycles, cyc);
    chk("res_data", res_data, tout ? '0 : rv);
    chk("dut_in", dut_in, tv);
    chk("starts", starts, (lim != 0 && lim <= d) ? 0 : 1);
    if (starts == 1) chk("start_at", start_at, d + 1);
    chk("requests", reqs, tout ? 0 : 1);
    chk("vec_count", vec_count, m_vec);
    chk("to_count", to_count, m_to);
    if (hold > 0) chk("hold_stable", stable, 1);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk("res_valid_drop", res_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    abort = 1'b0;
    timeout_limit = '0;
    tv_valid = 1'b0;
    tv_data = '0;
    dut_ready = 1'b0;
    dut_valid = 1'b0;
    dut_result = '0;
    res_ready = 1'b0;
    #2;
    chk("rst_tv_ready", tv_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_dut_in", dut_in, 0);
    chk("rst_vec", vec_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("tv_ready_first", tv_ready, 1);

    // nominal, timeout, DUT busy, valid/timeout race, backpressure
    run_vec(111'h1234, 200'hABC, 0, 6, 0, 1'b0, 0);
    run_vec(rand_tv(), rand_rv(), 0, 1000, 10, 1'b0, 0);
    run_vec(rand_tv(), rand_rv(), 4, 9, 0, 1'b1, 0);
    run_vec(rand_tv(), rand_rv(), 0, 8, 8, 1'b0, 0);
    run_vec(rand_tv(), rand_rv(), 1, 4, 0, 1'b0, 20);
    run_vec(rand_tv(), rand_rv(), 3, 6, 2, 1'b0, 2);

    // abort while waiting for the DUT result
    offer(rand_tv(), 0);
    dut_ready = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_tv_ready", tv_ready, 1);
    chk("abort_vec", vec_count, m_vec);
    chk("abort_to", to_count, m_to);

    for (int i = 0; i < 30; i++) begin
      int d;
      int v;
      int lim;
      d   = $urandom_range(0, 4);
      v   = d + 1 + $urandom_range(0, 12);
      lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
      run_vec(rand_tv(), rand_rv(), d, v, lim, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3));
    end

    // asynchronous reset in the middle of WAIT
    offer(rand_tv(), 0);
    dut_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    m_vec = 0;
    m_to  = 0;
    chk("arst_busy", busy, 0);
    chk("arst_dut_in", dut_in, 0);
    chk("arst_tv_ready", tv_ready, 0);
    chk("arst_start", dut_start, 0);
    chk("arst_vec", vec_count, 0);
    chk("arst_to", to_count, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_tv_ready_up", tv_ready, 1);
    run_vec(rand_tv(), rand_rv(), 2, 5, 0, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
